// File: rtl/mix_column_unit.sv
// Serial AES MixColumns engine: one output byte per cycle over a valid/ready column interface.
// Define MIX_COLUMN_INV_EN to add the in_inv port and InvMixColumns coefficients.
module mix_column_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
`ifdef MIX_COLUMN_INV_EN
  input  logic        in_inv,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  idx_r;
  logic [31:0] col_r;
  logic [31:0] out_col_r;
  logic        mode_s;
  logic [7:0]  byte_s;
  logic [1:0]  k_s;

  // Shift-and-add GF(2^8) product, reducing by 0x11B whenever bit 7 shifts out.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Row-0 coefficient k of the circulant matrix; row r uses index (c - r) mod 4.
  function automatic logic [7:0] coef(input logic [1:0] k, input logic inv);
    logic [7:0] c;
    case ({inv, k})
      3'b000:  c = 8'h02;
      3'b001:  c = 8'h03;
      3'b010:  c = 8'h01;
      3'b011:  c = 8'h01;
`ifdef MIX_COLUMN_INV_EN
      3'b100:  c = 8'h0E;
      3'b101:  c = 8'h0B;
      3'b110:  c = 8'h0D;
      3'b111:  c = 8'h09;
`endif
      default: c = 8'h00;
    endcase
    return c;
  endfunction

`ifdef MIX_COLUMN_INV_EN
  logic inv_r;
  assign mode_s = inv_r;
`else
  assign mode_s = 1'b0;
`endif

  // Four parallel multipliers produce output byte idx from the latched column.
  always_comb begin
    byte_s = 8'h00;
    k_s    = 2'd0;
    for (int c = 0; c < 4; c++) begin
      k_s    = c[1:0] - idx_r;
      byte_s = byte_s ^ gf_mul(coef(k_s, mode_s), col_r[31-8*c -: 8]);
    end
  end

  // Control FSM, operand capture and serial result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= 2'd0;
      col_r     <= 32'h0;
      out_col_r <= 32'h0;
`ifdef MIX_COLUMN_INV_EN
      inv_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            col_r     <= in_col;
`ifdef MIX_COLUMN_INV_EN
            inv_r     <= in_inv;
`endif
            idx_r     <= 2'd0;
            out_col_r <= 32'h0;
            state_r   <= CALC;
          end
        end
        CALC: begin
          case (idx_r)
            2'd0:    out_col_r[31:24] <= byte_s;
            2'd1:    out_col_r[23:16] <= byte_s;
            2'd2:    out_col_r[15:8]  <= byte_s;
            2'd3:    out_col_r[7:0]   <= byte_s;
            default: out_col_r        <= out_col_r;
          endcase
          idx_r <= idx_r + 2'd1;
          if (idx_r == 2'd3) state_r <= DONE;
        end
        DONE: begin
          if (out_ready) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == CALC) || (state_r == DONE);
  assign out_col   = out_col_r;

endmodule

// File: tb/tb_mix_column_unit.sv
// Self-checking bench for mix_column_unit: directed spec vectors plus random columns
// compared against a polynomial-arithmetic reference model.
module tb_mix_column_unit;
  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_col = 32'h0;
  logic        in_inv = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_col;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #(PERIOD/2) clk = ~clk;

  mix_column_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
`ifdef MIX_COLUMN_INV_EN
    .in_inv    (in_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .busy      (busy)
  );

  // Full polynomial product then long division by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--)
      if (p[k]) p = p ^ (16'h011B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] ref_mix(input logic [31:0] col, input logic inv);
    logic [7:0] row0 [4];
    logic [7:0] s [4];
    logic [7:0] r_out;
    logic [31:0] res;
    if (inv) begin
      row0[0] = 8'h0E; row0[1] = 8'h0B; row0[2] = 8'h0D; row0[3] = 8'h09;
    end else begin
      row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) s[c] = col[31-8*c -: 8];
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      r_out = 8'h00;
      for (int c = 0; c < 4; c++) r_out = r_out ^ ref_mul(row0[(c - r + 4) % 4], s[c]);
      res = (res << 8) | 32'(r_out);
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one column, measure accept-to-out_valid latency, check the result.
  task automatic send(input logic [31:0] col, input logic inv, output time t_acc);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_col   = col;
    in_inv   = inv;
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    t_acc = $time;
    #1;
    in_valid = 1'b0;
    in_col   = $urandom;
    in_inv   = 1'($urandom);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", 32'(lat), 32'd4);
    check("out_col_model", out_col, ref_mix(col, inv));
  endtask

  // Complete the output handshake and confirm IDLE is re-entered.
  task automatic drain();
    if (!out_ready) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("idle_after_hs", {30'b0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    time t0, t1, t2;
    logic [31:0] col;
    logic inv;
    logic held;

    #2;
    check("reset_outputs", {28'b0, in_ready, out_valid, busy, 1'b0}, 32'h8);
    check("reset_out_col", out_col, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    out_ready = 1'b1;
    send(32'hDB135345, 1'b0, t0);
    check("fwd_vector", out_col, 32'h8E4DA1BC);
    drain();

    send(32'h01010101, 1'b0, t0);
    check("identity_01", out_col, 32'h01010101);
    drain();
    send(32'hC6C6C6C6, 1'b0, t1);
    check("identity_c6", out_col, 32'hC6C6C6C6);
    drain();
    send(32'hF20A225C, 1'b0, t2);
    check("fwd_f20a", out_col, 32'h9FDC589D);
    drain();
    check("spacing_1", 32'((t1 - t0) / PERIOD), 32'd6);
    check("spacing_2", 32'((t2 - t1) / PERIOD), 32'd6);

    out_ready = 1'b0;
    send(32'hD4D4D4D5, 1'b0, t0);
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      in_col   = $urandom;
      if (out_col !== 32'hD5D5D7D6 || in_ready !== 1'b0 || out_valid !== 1'b1) held = 1'b0;
    end
    check("backpressure_hold", {31'b0, held}, 32'd1);
    in_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("no_capture_in_done", {31'b0, busy}, 32'd0);
    check("out_col_kept", out_col, 32'hD5D5D7D6);

`ifdef MIX_COLUMN_INV_EN
    out_ready = 1'b1;
    send(32'h8E4DA1BC, 1'b1, t0);
    check("inv_vector_1", out_col, 32'hDB135345);
    drain();
    send(32'h4D7EBDF8, 1'b1, t0);
    check("inv_vector_2", out_col, 32'h2D26314C);
    drain();
`endif

    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_col   = 32'h2D26314C;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("busy_mid_calc", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_calc_ctl", {29'b0, in_ready, out_valid, busy}, 32'd4);
    check("rst_mid_calc_col", out_col, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) held = 1'b0;
    end
    check("no_valid_after_rst", {31'b0, held}, 32'd1);
    send(32'h2D26314C, 1'b0, t0);
    check("fwd_after_rst", out_col, 32'h4D7EBDF8);
    drain();

    for (int i = 0; i < 24; i++) begin
      col = $urandom;
`ifdef MIX_COLUMN_INV_EN
      inv = 1'($urandom);
`else
      inv = 1'b0;
`endif
      out_ready = 1'($urandom);
      send(col, inv, t0);
      if (!out_ready) begin
        held = 1'b1;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          if (out_valid !== 1'b1) held = 1'b0;
        end
        check("rand_hold", {31'b0, held}, 32'd1);
      end
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
